// File: rtl/regwrite_arbiter_if.sv
// Register-file write-port bundle: two requesters in, one registered write out.
interface regwrite_arbiter_if;
  logic        stall;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        sel;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  starve_cnt;

  // Arbiter side
  modport slave (
    input  stall,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output sel, wr_en, wr_addr, wr_data, starve_cnt
  );

  // Requester / register-file side
  modport master (
    output stall,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  sel, wr_en, wr_addr, wr_data, starve_cnt
  );
endinterface

// File: rtl/regwrite_arbiter.sv
// Two-port register-file write arbiter with starvation-driven priority swap.
//
// state | meaning
// PRI0  | port 0 (ALU writeback) wins when both ports are valid
// PRI1  | port 1 (multicycle/load) wins when both ports are valid
module regwrite_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  regwrite_arbiter_if.slave  bus
);

  localparam logic [0:0] PRI0  = 1'b0;
  localparam logic [0:0] PRI1  = 1'b1;
  localparam logic [3:0] C_MAX = 4'(STARVE_MAX);

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_g0;
  logic        w_g1;
  logic        w_hs;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        r_sel;
  logic        r_wr_en;
  logic [4:0]  r_wr_addr;
  logic [31:0] r_wr_data;

  // Combinational grant: lone requester always wins, contention resolved by state
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (!rst && !bus.stall) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (r_state == PRI1) w_g1 = 1'b1;
        else                 w_g0 = 1'b1;
      end else begin
        w_g0 = bus.req0_valid;
        w_g1 = bus.req1_valid;
      end
    end
  end

  assign w_hs   = w_g0 | w_g1;
  assign w_addr = w_g1 ? bus.req1_addr : bus.req0_addr;
  assign w_data = w_g1 ? bus.req1_data : bus.req0_data;

  // Starvation count and priority state; everything freezes during stall
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    if (!bus.stall) begin
      if (bus.req1_valid && !w_g1) begin
        w_cnt_nxt = (r_cnt >= C_MAX) ? C_MAX : r_cnt + 4'd1;
      end else begin
        w_cnt_nxt = 4'd0;
      end
      if (r_state == PRI0) begin
        if (w_cnt_nxt == C_MAX) w_state_nxt = PRI1;
      end else begin
        if (w_g1 || !bus.req1_valid) w_state_nxt = PRI0;
      end
    end
  end

  // Priority state and starvation counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PRI0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered write port; r0 writes are accepted but never enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 5'd0;
      r_wr_data <= 32'd0;
    end else if (w_hs) begin
      r_sel     <= w_g1;
      r_wr_en   <= (w_addr != 5'd0);
      r_wr_addr <= w_addr;
      r_wr_data <= w_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign bus.req0_ready = w_g0;
  assign bus.req1_ready = w_g1;
  assign bus.sel        = r_sel;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.starve_cnt = r_cnt;

endmodule
